// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module      : keypad_pkg
// Description : Key codes, column/row patterns, FSM states and key lookup
//               for the 4x3 keypad emulator.
// Revision    : 1.0 - initial release
// ============================================================================
package keypad_pkg;

    localparam logic [3:0] KEY_0    = 4'd0;
    localparam logic [3:0] KEY_1    = 4'd1;
    localparam logic [3:0] KEY_2    = 4'd2;
    localparam logic [3:0] KEY_3    = 4'd3;
    localparam logic [3:0] KEY_4    = 4'd4;
    localparam logic [3:0] KEY_5    = 4'd5;
    localparam logic [3:0] KEY_6    = 4'd6;
    localparam logic [3:0] KEY_7    = 4'd7;
    localparam logic [3:0] KEY_8    = 4'd8;
    localparam logic [3:0] KEY_9    = 4'd9;
    localparam logic [3:0] KEY_HASH = 4'd10;
    localparam logic [3:0] KEY_STAR = 4'd11;

    localparam logic [3:0] COL0 = 4'b0111;
    localparam logic [3:0] COL1 = 4'b1011;
    localparam logic [3:0] COL2 = 4'b1101;

    localparam logic [3:0] ROW0 = 4'b0111;
    localparam logic [3:0] ROW1 = 4'b1011;
    localparam logic [3:0] ROW2 = 4'b1101;
    localparam logic [3:0] ROW3 = 4'b1110;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_BOUNCE_IN  = 3'd1;
    localparam logic [2:0] ST_HOLD       = 3'd2;
    localparam logic [2:0] ST_BOUNCE_OUT = 3'd3;
    localparam logic [2:0] ST_GAP        = 3'd4;

    typedef struct packed {
        logic       valid;
        logic [1:0] col;
        logic [1:0] row;
    } key_pos_t;

    function automatic key_pos_t key_lookup(input logic [3:0] code);
        key_pos_t p;
        p = '{1'b0, 2'd0, 2'd0};
        case (code)
            KEY_1:    p = '{1'b1, 2'd0, 2'd0};
            KEY_2:    p = '{1'b1, 2'd1, 2'd0};
            KEY_3:    p = '{1'b1, 2'd2, 2'd0};
            KEY_4:    p = '{1'b1, 2'd0, 2'd1};
            KEY_5:    p = '{1'b1, 2'd1, 2'd1};
            KEY_6:    p = '{1'b1, 2'd2, 2'd1};
            KEY_7:    p = '{1'b1, 2'd0, 2'd2};
            KEY_8:    p = '{1'b1, 2'd1, 2'd2};
            KEY_9:    p = '{1'b1, 2'd2, 2'd2};
            KEY_STAR: p = '{1'b1, 2'd0, 2'd3};
            KEY_0:    p = '{1'b1, 2'd1, 2'd3};
            KEY_HASH: p = '{1'b1, 2'd2, 2'd3};
            default:  p = '{1'b0, 2'd0, 2'd0};
        endcase
        return p;
    endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_matrix_emulator_lfsr16.sv
`default_nettype none
// ============================================================================
// Module      : lfsr16
// Description : 16-bit Fibonacci LFSR (taps 16,14,13,11) used as contact
//               chatter source; advances only while enabled.
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic bit_out
);

    logic [15:0] r_lfsr;
    logic        w_fb;

    // Right-shifting form: taps 16,14,13,11 land on bits 0,2,3,5.
    assign w_fb    = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
    assign bit_out = r_lfsr[0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lfsr <= SEED;
        end else if (en) begin
            r_lfsr <= {w_fb, r_lfsr[15:1]};
        end
    end

endmodule
`default_nettype wire

// File: rtl/keypad_matrix_emulator.sv
`default_nettype none
// ============================================================================
// Module      : keypad_matrix_emulator
// Description : Passive 4x3 keypad model; shapes a requested key press into
//               bounce-in, hold, bounce-out and gap phases on row lines.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_matrix_emulator #(
    parameter int HOLD_CYCLES   = 1_000_000,
    parameter int BOUNCE_CYCLES = 50_000,
    parameter int GAP_CYCLES    = 100_000,
    parameter int CNT_W         = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] key_code,
    input  logic       press_valid,
    output logic       press_ready,
    input  logic [3:0] coluna,
    output logic [3:0] linha,
    output logic       busy,
    output logic       done,
    output logic       err
);
    import keypad_pkg::*;

    localparam logic             c_has_bounce = (BOUNCE_CYCLES > 0);
    localparam logic [CNT_W-1:0] c_one        = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_hold_ld    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_gap_ld     = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_bounce_ld  =
        (BOUNCE_CYCLES > 0) ? CNT_W'(BOUNCE_CYCLES - 1) : '0;

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_contact;
    logic             r_done;
    logic             r_err;
    logic [1:0]       r_col;
    logic [1:0]       r_row;

    key_pos_t         w_pos;
    logic             w_accept;
    logic             w_cnt_zero;
    logic             w_lfsr_en;
    logic             w_lfsr_bit;
    logic             w_unused_col0;

    assign w_pos         = key_lookup(key_code);
    assign w_accept      = press_valid && (r_state == ST_IDLE);
    assign w_cnt_zero    = (r_cnt == '0);
    assign w_lfsr_en     = (r_state == ST_BOUNCE_IN) || (r_state == ST_BOUNCE_OUT);
    assign w_unused_col0 = coluna[0];

    assign press_ready = (r_state == ST_IDLE);
    assign busy        = (r_state != ST_IDLE);
    assign done        = r_done;
    assign err         = r_err;

    lfsr16 #(
        .SEED    (16'hACE1)
    ) u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (w_lfsr_en),
        .bit_out (w_lfsr_bit)
    );

    // Contact behaves like a real switch: the scanner sees it only while
    // strobing the key's column, with no clock between strobe and row.
    always_comb begin
        linha = 4'b1111;
        if (r_contact && !coluna[2'd3 - r_col]) begin
            linha[2'd3 - r_row] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_contact <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_col     <= 2'd0;
            r_row     <= 2'd0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_contact <= 1'b0;
                    if (w_accept) begin
                        if (w_pos.valid) begin
                            r_col <= w_pos.col;
                            r_row <= w_pos.row;
                            if (c_has_bounce) begin
                                r_state <= ST_BOUNCE_IN;
                                r_cnt   <= c_bounce_ld;
                            end else begin
                                r_state <= ST_HOLD;
                                r_cnt   <= c_hold_ld;
                            end
                        end else begin
                            r_done <= 1'b1;
                            r_err  <= 1'b1;
                        end
                    end
                end
                ST_BOUNCE_IN: begin
                    r_contact <= w_lfsr_bit;
                    if (w_cnt_zero) begin
                        r_state <= ST_HOLD;
                        r_cnt   <= c_hold_ld;
                    end else begin
                        r_cnt <= r_cnt - c_one;
                    end
                end
                ST_HOLD: begin
                    r_contact <= 1'b1;
                    if (w_cnt_zero) begin
                        if (c_has_bounce) begin
                            r_state <= ST_BOUNCE_OUT;
                            r_cnt   <= c_bounce_ld;
                        end else begin
                            r_state <= ST_GAP;
                            r_cnt   <= c_gap_ld;
                        end
                    end else begin
                        r_cnt <= r_cnt - c_one;
                    end
                end
                ST_BOUNCE_OUT: begin
                    r_contact <= w_lfsr_bit;
                    if (w_cnt_zero) begin
                        r_state <= ST_GAP;
                        r_cnt   <= c_gap_ld;
                    end else begin
                        r_cnt <= r_cnt - c_one;
                    end
                end
                ST_GAP: begin
                    r_contact <= 1'b0;
                    if (w_cnt_zero) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - c_one;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_cnt     <= '0;
                    r_contact <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
